hazard_stall_controller: RTL and testbench
==========================================

// Module: hazard_stall_controller
// PURPOSE
//  Pipeline sequencing controller for the 5-stage RV32I core. It sits beside the decode control unit
//  and takes register addresses and decoded controls from the D/E/M/W stages plus the data-memory
//  ready handshake. It drives stall, flush and forward selects: load-use stall, branch/jump flush,
//  M/W forwarding, and a multi-cycle data-memory wait FSM with timeout and a stall performance counter.
// PARAMETERS
//  REG_ADDR_WIDTH  5    register index width
//  MAX_WAIT        255  memory-wait cycles before timeout error (>=1)
//  CNT_WIDTH       32   width of StallCount
// PORTS
//  clk          in   1    core clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  Rs1D,Rs2D    in   5    source regs in Decode
//  Rs1E,Rs2E    in   5    source regs in Execute
//  RdE          in   5    dest reg in Execute
//  ResultSrcE0  in   1    Execute instr is a load (ResultSrcE==2'b01)
//  PCSrcE       in   1    branch taken / jump in Execute
//  RdM,RdW      in   5    dest regs in Memory / Writeback
//  RegWriteM    in   1    Memory-stage instr writes rd
//  RegWriteW    in   1    Writeback-stage instr writes rd
//  MemReqM      in   1    load/store occupies Memory stage
//  MemReadyM    in   1    data memory completes access this cycle
//  StallF,StallD,StallE,StallM  out 1  hold stage registers
//  FlushD,FlushE,FlushW         out 1  bubble into stage registers
//  ForwardAE,ForwardBE          out 2  00 regfile, 01 W result, 10 M ALU result
//  MemErr       out  1    sticky memory-timeout error
//  StallCount   out  CNT_WIDTH  count of cycles with StallF=1 (saturating)
// BEHAVIOUR
//  FSM (registered): RUN, MEM_WAIT, ERROR. Reset -> RUN, wait counter=0, MemErr=0, StallCount=0.
//  memStall = (state==RUN & MemReqM & ~MemReadyM) | (state==MEM_WAIT & ~MemReadyM) | state==ERROR.
//  RUN: MemReqM & ~MemReadyM -> MEM_WAIT, counter<=1. Otherwise stay.
//  MEM_WAIT: MemReadyM -> RUN, counter<=0 (memStall=0 that cycle, pipeline advances);
//    else counter==MAX_WAIT -> ERROR, MemErr<=1; else counter++.
//  ERROR: terminal until rst_n; all four stalls=1, FlushW=1.
//  lwStall = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
//  memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0 (memStall beats all).
//  memStall=0: StallF=StallD=lwStall; StallE=StallM=0; FlushW=0;
//    FlushD=PCSrcE; FlushE=lwStall|PCSrcE (both may fire together; flush wins in D).
//  Forwarding (comb.), per operand X in {1,2}: 10 if RegWriteM & RdM!=0 & RdM==RsXE;
//    else 01 if RegWriteW & RdW!=0 & RdW==RsXE; else 00. M beats W. x0 is never forwarded.
//  All stall/flush/forward outputs are combinational, zero latency. With inputs at 0 after reset,
//    all are 0.
//  StallCount increments each cycle StallF=1 and saturates at all-ones.
//  Async reset mid-MEM_WAIT or in ERROR returns to RUN immediately; counters clear.
// TESTING
//  1 lw x5 in E (ResultSrcE0=1,RdE=5), Rs1D=5 -> StallF=StallD=FlushE=1 for 1 cycle; RdE=0 -> no stall.
//  2 RdM=RdW=7, both RegWrite=1, Rs1E=7 -> ForwardAE=10; clear RegWriteM -> 01; Rs2E=0,RdM=0 -> ForwardBE=00.
//  3 PCSrcE=1 with lwStall=1 -> FlushD=1, FlushE=1; StallF/StallD=1 is legal alongside.
//  4 MemReqM=1, MemReadyM low 3 cycles then high -> 3 cycles of all stalls+FlushW; FlushD/E=0 while
//    PCSrcE=1; RUN after; StallCount+=3.
//  5 MAX_WAIT=4, MemReadyM held 0 -> ERROR after counter reaches 4, MemErr=1 sticky, stalls held.
//  6 rst_n pulsed low mid-MEM_WAIT (async, between edges) -> state RUN, MemErr=0, StallCount=0 at once.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Hazard and stall sequencing for the 5-stage RV32I pipeline.
// Combines load-use stalls, branch/jump flushes, M/W operand forwarding and
// a data-memory wait FSM with timeout. The memory wait overrides every other
// hazard. A saturating counter records how many cycles fetch was held.
module hazard_stall_controller #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MAX_WAIT       = 255,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic                      ResultSrcE0,
  input  logic                      PCSrcE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      MemReqM,
  input  logic                      MemReadyM,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      MemErr,
  output logic [CNT_WIDTH-1:0]      StallCount
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_CNT = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  state_t                state_q;
  logic [WAIT_W-1:0]     waitCnt_q;
  logic                  memErr_q;
  logic [CNT_WIDTH-1:0]  stallCount_q;
  logic [CNT_WIDTH-1:0]  stallCount_d;
  logic                  memStall;
  logic                  lwStall;

  // Pick the forwarding source for one Execute operand; M is younger so it wins, x0 never forwards.
  function automatic logic [1:0] forwardSel(input logic [REG_ADDR_WIDTH-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == rs)) begin
      sel = 2'b10;
    end else if (RegWriteW && (RdW != '0) && (RdW == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Decode the two stall sources: memory wait (FSM driven) and load-use in Execute.
  always_comb begin
    memStall = 1'b0;
    lwStall  = 1'b0;
    case (state_q)
      RUN:      memStall = MemReqM & ~MemReadyM;
      MEM_WAIT: memStall = ~MemReadyM;
      default:  memStall = 1'b1;
    endcase
    lwStall = ResultSrcE0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));
  end

  // Stage hold/bubble selection; a memory stall freezes everything and suppresses flushes.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lwStall;
      StallD = lwStall;
      FlushD = PCSrcE;
      FlushE = lwStall | PCSrcE;
    end
  end

  // Operand forwarding selects for both Execute sources.
  always_comb begin
    ForwardAE = forwardSel(Rs1E);
    ForwardBE = forwardSel(Rs2E);
  end

  // Saturating next value of the fetch-stall counter.
  always_comb begin
    stallCount_d = stallCount_q;
    if (StallF && (stallCount_q != '1)) begin
      stallCount_d = stallCount_q + CNT_WIDTH'(1);
    end
  end

  // Memory-wait FSM with timeout; the error state is only left through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      waitCnt_q <= '0;
      memErr_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (MemReqM && !MemReadyM) begin
            state_q   <= MEM_WAIT;
            waitCnt_q <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (MemReadyM) begin
            state_q   <= RUN;
            waitCnt_q <= '0;
          end else if (waitCnt_q == MAX_WAIT_CNT) begin
            state_q  <= ERROR;
            memErr_q <= 1'b1;
          end else begin
            waitCnt_q <= waitCnt_q + WAIT_W'(1);
          end
        end
        default: begin
          state_q  <= ERROR;
          memErr_q <= 1'b1;
        end
      endcase
    end
  end

  // Stall performance counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCount_q <= '0;
    end else begin
      stallCount_q <= stallCount_d;
    end
  end

  assign MemErr     = memErr_q;
  assign StallCount = stallCount_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: a table of combinational hazard
// vectors followed by hand-written memory-wait, timeout, saturation and
// asynchronous-reset sequences.
module tb_hazard_stall_controller;

  localparam int CW = 6;

  logic          clk;
  logic          rst_n;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] StallCount;

  int total;
  int bad;

  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
    logic       ld, pc;
    logic [4:0] rdM, rdW;
    logic       rwM, rwW;
    logic       sF, sD, sE, sM, fD, fE, fW;
    logic [1:0] fA, fB;
  } vec_t;

  vec_t vecs[13];

  hazard_stall_controller #(
    .REG_ADDR_WIDTH(5),
    .MAX_WAIT(4),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCount(StallCount)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkStalls(input string tag, input logic sF, input logic sD, input logic sE,
                             input logic sM, input logic fD, input logic fE, input logic fW);
    checkOutput({tag, " StallF"}, 32'(StallF), 32'(sF));
    checkOutput({tag, " StallD"}, 32'(StallD), 32'(sD));
    checkOutput({tag, " StallE"}, 32'(StallE), 32'(sE));
    checkOutput({tag, " StallM"}, 32'(StallM), 32'(sM));
    checkOutput({tag, " FlushD"}, 32'(FlushD), 32'(fD));
    checkOutput({tag, " FlushE"}, 32'(FlushE), 32'(fE));
    checkOutput({tag, " FlushW"}, 32'(FlushW), 32'(fW));
  endtask

  task automatic driveIdle();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE0 = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    Rs1D = v.rs1D; Rs2D = v.rs2D; Rs1E = v.rs1E; Rs2E = v.rs2E; RdE = v.rdE;
    ResultSrcE0 = v.ld; PCSrcE = v.pc; RdM = v.rdM; RdW = v.rdW;
    RegWriteM = v.rwM; RegWriteW = v.rwW;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //           rs1D rs2D rs1E rs2E rdE ld pc rdM rdW rwM rwW  sF sD sE sM fD fE fW  fA     fB
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vecs[1]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00};
    vecs[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vecs[3]  = '{5'd1, 5'd5, 5'd0, 5'd0, 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00};
    vecs[4]  = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vecs[5]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 5'd7, 5'd7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00};
    vecs[6]  = '{5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 5'd7, 5'd7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00};
    vecs[7]  = '{5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 0, 0, 5'd0, 5'd7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    vecs[9]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 0, 0, 5'd9, 5'd3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00};
    vecs[11] = '{5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 1, 1, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00};
    vecs[12] = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 0, 0, 5'd6, 5'd4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};

    driveIdle();
    MemReqM   = 1'b0;
    MemReadyM = 1'b0;
    rst_n     = 1'b0;
    #2;
    checkStalls("reset", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset ForwardAE", 32'(ForwardAE), 32'd0);
    checkOutput("reset ForwardBE", 32'(ForwardBE), 32'd0);
    checkOutput("reset MemErr", 32'(MemErr), 32'd0);
    checkOutput("reset StallCount", 32'(StallCount), 32'd0);

    // Combinational vectors, applied while held in reset so the counter stays put.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkStalls($sformatf("v%0d", i), vecs[i].sF, vecs[i].sD, vecs[i].sE, vecs[i].sM,
                  vecs[i].fD, vecs[i].fE, vecs[i].fW);
      checkOutput($sformatf("v%0d ForwardAE", i), 32'(ForwardAE), 32'(vecs[i].fA));
      checkOutput($sformatf("v%0d ForwardBE", i), 32'(ForwardBE), 32'(vecs[i].fB));
    end

    driveIdle();
    @(negedge clk);
    rst_n = 1'b1;

    // Three wait cycles with a taken branch pending, then the memory completes.
    @(negedge clk);
    MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkStalls($sformatf("memwait c%0d", c), 1, 1, 1, 1, 0, 0, 1);
      @(negedge clk);
    end
    MemReadyM = 1'b1;
    #1;
    checkStalls("memready", 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    MemReqM = 1'b0; PCSrcE = 1'b0;
    #1;
    checkStalls("after wait", 0, 0, 0, 0, 0, 0, 0);
    checkOutput("after wait StallCount", 32'(StallCount), 32'd3);
    MemReqM = 1'b1;
    #1;
    checkOutput("run ready StallF", 32'(StallF), 32'd0);

    // Timeout: memory never answers, error after the wait counter reaches 4.
    @(negedge clk);
    MemReqM = 1'b1; MemReadyM = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("timeout c%0d StallF", c), 32'(StallF), 32'd1);
      checkOutput($sformatf("timeout c%0d MemErr", c), 32'(MemErr), 32'd0);
      @(negedge clk);
    end
    #1;
    checkOutput("error MemErr", 32'(MemErr), 32'd1);
    MemReqM = 1'b0; MemReadyM = 1'b1; PCSrcE = 1'b1;
    #1;
    checkStalls("error", 1, 1, 1, 1, 0, 0, 1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("error sticky MemErr", 32'(MemErr), 32'd1);
    checkOutput("error sticky StallF", 32'(StallF), 32'd1);
    repeat (70) @(negedge clk);
    #1;
    checkOutput("saturated StallCount", 32'(StallCount), 32'd63);

    // Asynchronous reset out of the error state, between clock edges.
    PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst from error MemErr", 32'(MemErr), 32'd0);
    checkOutput("rst from error StallCount", 32'(StallCount), 32'd0);
    checkOutput("rst from error StallF", 32'(StallF), 32'd0);
    #1;
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a memory wait.
    @(negedge clk);
    MemReqM = 1'b1; MemReadyM = 1'b0;
    #1;
    checkOutput("wait2 enter StallF", 32'(StallF), 32'd1);
    @(negedge clk);
    MemReqM = 1'b0;
    #1;
    checkOutput("wait2 held StallF", 32'(StallF), 32'd1);
    checkOutput("wait2 StallCount", 32'(StallCount), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst mid wait StallF", 32'(StallF), 32'd0);
    checkOutput("rst mid wait StallCount", 32'(StallCount), 32'd0);
    checkOutput("rst mid wait MemErr", 32'(MemErr), 32'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("post reset StallF", 32'(StallF), 32'd0);
    checkOutput("post reset StallCount", 32'(StallCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
